calc_operand_sequencer: RTL and testbench
=========================================

Name: calc_operand_sequencer

Overview:
- Front-end controller for the pocket-calculator datapath.
- Captures two 10-bit operands entered on switches, one per LOAD strobe, and widens each to 16 bits through the existing 10-to-16 zero-extend converter.
- Issues a single-cycle start to the ALU with the selected opcode, waits for completion or timeout, then holds the result for display until cleared or a new entry begins.

Parameters:
- OPW, 3, opcode width.
- TIMEOUT, 255, maximum cycles to wait for ALU_DONE after ALU_START before declaring an error.
- TW, 8, timeout counter width; must satisfy 2^TW > TIMEOUT.

Ports:
- CLK  in  1  system clock, all state on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- DATA_IN  in  10  switch value, sampled only in the LOAD cycle.
- LOAD  in  1  single-cycle entry strobe (debounced upstream).
- OPCODE  in  OPW  operation select, sampled in the cycle the second operand is accepted.
- CLEAR  in  1  synchronous abort/clear; highest priority after reset.
- ALU_DONE  in  1  ALU completion pulse.
- ALU_ERR  in  1  ALU error flag (e.g. divide by zero), valid with ALU_DONE.
- ALU_RESULT  in  16  ALU output, valid with ALU_DONE.
- OP_A  out  16  zero-extended first operand.
- OP_B  out  16  zero-extended second operand.
- ALU_OP  out  OPW  latched opcode.
- ALU_START  out  1  one-cycle start pulse.
- RESULT  out  16  latched result.
- RESULT_VALID  out  1  RESULT holds a completed, error-free result.
- ERROR  out  1  ALU error or timeout occurred.
- BUSY  out  1  high in EXEC and WAIT_ALU.
- STATE  out  3  current state code, for display/debug.

Behaviour:
- Reset (RST_N low, asynchronous):
  - state IDLE.
  - OP_A, OP_B, RESULT, ALU_OP, timeout counter = 0.
  - ALU_START, RESULT_VALID, ERROR, BUSY = 0.
- State codes: IDLE=0, WAIT_B=1, EXEC=2, WAIT_ALU=3, SHOW=4, FAULT=5; codes 6 and 7 recover to IDLE on the next edge.
- Widening: OP_x[15:10] = 0 and OP_x[9:0] = DATA_IN. No sign extension. Only this path writes OP_A and OP_B.
- IDLE:
  - LOAD: OP_A <= widened DATA_IN; go to WAIT_B.
  - No LOAD: hold.
- WAIT_B:
  - LOAD: OP_B <= widened DATA_IN; ALU_OP <= OPCODE; go to EXEC.
- EXEC:
  - Lasts exactly one cycle; ALU_START = 1 in this cycle only.
  - Timeout counter <= 0; go to WAIT_ALU.
- WAIT_ALU:
  - ALU_DONE with ALU_ERR = 0: RESULT <= ALU_RESULT; RESULT_VALID <= 1; go to SHOW.
  - ALU_DONE with ALU_ERR = 1: ERROR <= 1; RESULT unchanged; go to FAULT.
  - Otherwise counter increments. When counter == TIMEOUT with no ALU_DONE: ERROR <= 1; go to FAULT.
  - ALU_DONE in the same cycle as counter == TIMEOUT: ALU_DONE wins.
  - LOAD is ignored.
- SHOW:
  - RESULT and RESULT_VALID hold.
  - LOAD: RESULT_VALID <= 0; OP_A <= widened DATA_IN; go to WAIT_B. This is the chained-entry path; OP_B keeps its old value until overwritten.
- FAULT:
  - ERROR holds; LOAD ignored.
  - Only CLEAR or reset exits.
- CLEAR (any state):
  - Next state IDLE.
  - RESULT_VALID, ERROR, counter = 0.
  - OP_A, OP_B, RESULT, ALU_OP retain their values.
  - Same-cycle LOAD is ignored.
  - CLEAR during WAIT_ALU abandons the operation. A late ALU_DONE seen in IDLE is ignored.
- Latency:
  - Second LOAD edge to ALU_START = 1 cycle.
  - ALU_DONE to RESULT_VALID = 1 cycle.
- BUSY is decoded combinationally from the state register; all other outputs are registered.
- ALU_DONE or ALU_ERR outside WAIT_ALU has no effect.
- Reset asserted mid-operation returns all outputs to reset values immediately (asynchronous).

Decomposition:
- Shared package calc_pkg holds:
  - state encoding constants IDLE..FAULT (3 bits);
  - opcode constants ADD=0, SUB=1, MUL=2, DIV=3;
  - widths OPERAND_IN_W=10 and DATA_W=16.
- Instantiate the existing 10-to-16 zero-extend converter once, fed from DATA_IN; its output drives both OP_A and OP_B loads.
- One new sub-module, calc_timeout_counter: clear, enable, count == limit flag, parameterised by TW.

Test Plan:
- Normal add: reset; LOAD 10'b1101100110; LOAD 10'b1111111111 with OPCODE=0; ALU_DONE 3 cycles after start with RESULT 16'h0765 -> OP_A=16'h0366, OP_B=16'h03FF, one-cycle ALU_START, RESULT=16'h0765, RESULT_VALID=1, STATE=4.
- Widening bounds: operands 10'b1000000000 and 10'b0111111111 -> OP_A=16'h0200, OP_B=16'h01FF, upper 6 bits zero.
- Timeout: ALU_DONE never asserted -> ERROR=1 and STATE=5 exactly TIMEOUT+1 cycles after ALU_START; LOAD ignored; CLEAR -> STATE=0, ERROR=0.
- ALU error and tie: ALU_DONE with ALU_ERR=1 -> FAULT with RESULT unchanged; separately, ALU_DONE in the timeout cycle -> SHOW, ERROR=0.
- Chained entry: in SHOW, LOAD 10'b1010101010 -> RESULT_VALID=0, OP_A=16'h02AA, STATE=1.
- Resets: async RST_N pulse mid-WAIT_ALU (off clock edge) -> all outputs zero immediately. CLEAR with simultaneous LOAD in IDLE -> stays IDLE, OP_A unchanged.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator front end: state codes, opcodes and widths.
package calc_pkg;

   localparam int OPERAND_IN_W = 10;
   localparam int DATA_W       = 16;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_B   = 3'd1,
      EXEC     = 3'd2,
      WAIT_ALU = 3'd3,
      SHOW     = 3'd4,
      FAULT    = 3'd5
   } state_t;

   localparam logic [2:0] ADD = 3'd0;
   localparam logic [2:0] SUB = 3'd1;
   localparam logic [2:0] MUL = 3'd2;
   localparam logic [2:0] DIV = 3'd3;

endpackage

// File: rtl/calc_timeout_counter.sv
// Cycle counter with synchronous clear, count enable and a count == limit flag.
module calc_timeout_counter #(
   parameter int TW    = 8,
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic at_limit
);

   logic [TW-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign at_limit = (cnt_q == TW'(LIMIT));

endmodule

// File: rtl/calc_zext_10_16.sv
// 10-to-16 zero-extend converter for switch-entered operands.
module calc_zext_10_16
   import calc_pkg::*;
(
   input  logic [OPERAND_IN_W-1:0] din,
   output logic [DATA_W-1:0]       dout
);

   assign dout = {{(DATA_W-OPERAND_IN_W){1'b0}}, din};

endmodule

// File: rtl/calc_operand_sequencer.sv
// Front-end controller: captures two operands, starts the ALU and holds its result
// for display until cleared or a new entry begins.
module calc_operand_sequencer
   import calc_pkg::*;
#(
   parameter int OPW     = 3,
   parameter int TIMEOUT = 255,
   parameter int TW      = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [OPERAND_IN_W-1:0] data_in,
   input  logic                    load,
   input  logic [OPW-1:0]          opcode,
   input  logic                    clear,
   input  logic                    alu_done,
   input  logic                    alu_err,
   input  logic [DATA_W-1:0]       alu_result,
   output logic [DATA_W-1:0]       op_a,
   output logic [DATA_W-1:0]       op_b,
   output logic [OPW-1:0]          alu_op,
   output logic                    alu_start,
   output logic [DATA_W-1:0]       result,
   output logic                    result_valid,
   output logic                    error,
   output logic                    busy,
   output logic [2:0]              state
);

   state_t            state_q;
   logic [DATA_W-1:0] data_wide;
   logic              at_limit;

   calc_zext_10_16 u_zext (
      .din  (data_in),
      .dout (data_wide)
   );

   // Counter restarts on the EXEC cycle so it measures cycles spent in WAIT_ALU.
   calc_timeout_counter #(
      .TW    (TW),
      .LIMIT (TIMEOUT)
   ) u_timeout (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clear || (state_q == EXEC)),
      .en       ((state_q == WAIT_ALU) && !alu_done),
      .at_limit (at_limit)
   );

   // NOTE: all state updates use non-blocking assignments so every register in this
   // block samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         op_a         <= '0;
         op_b         <= '0;
         alu_op       <= '0;
         alu_start    <= 1'b0;
         result       <= '0;
         result_valid <= 1'b0;
         error        <= 1'b0;
      end else begin
         alu_start <= 1'b0;
         if (clear) begin
            state_q      <= IDLE;
            result_valid <= 1'b0;
            error        <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (load) begin
                     op_a    <= data_wide;
                     state_q <= WAIT_B;
                  end
               end
               WAIT_B: begin
                  if (load) begin
                     op_b      <= data_wide;
                     alu_op    <= opcode;
                     alu_start <= 1'b1;
                     state_q   <= EXEC;
                  end
               end
               EXEC: state_q <= WAIT_ALU;
               WAIT_ALU: begin
                  // A completion in the limit cycle takes precedence over the timeout.
                  if (alu_done) begin
                     if (alu_err) begin
                        error   <= 1'b1;
                        state_q <= FAULT;
                     end else begin
                        result       <= alu_result;
                        result_valid <= 1'b1;
                        state_q      <= SHOW;
                     end
                  end else if (at_limit) begin
                     error   <= 1'b1;
                     state_q <= FAULT;
                  end
               end
               SHOW: begin
                  if (load) begin
                     result_valid <= 1'b0;
                     op_a         <= data_wide;
                     state_q      <= WAIT_B;
                  end
               end
               FAULT:   state_q <= FAULT;
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign busy  = (state_q == EXEC) || (state_q == WAIT_ALU);
   assign state = state_q;

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// Directed-vector bench for calc_operand_sequencer with hand-computed expectations.
module tb_calc_operand_sequencer;
   import calc_pkg::*;

   localparam int TIMEOUT = 255;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  data_in;
   logic        load;
   logic [2:0]  opcode;
   logic        clear;
   logic        alu_done;
   logic        alu_err;
   logic [15:0] alu_result;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic [2:0]  alu_op;
   logic        alu_start;
   logic [15:0] result;
   logic        result_valid;
   logic        error;
   logic        busy;
   logic [2:0]  state;

   int vectors = 0;
   int errors  = 0;

   calc_operand_sequencer #(.OPW(3), .TIMEOUT(TIMEOUT), .TW(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .data_in      (data_in),
      .load         (load),
      .opcode       (opcode),
      .clear        (clear),
      .alu_done     (alu_done),
      .alu_err      (alu_err),
      .alu_result   (alu_result),
      .op_a         (op_a),
      .op_b         (op_b),
      .alu_op       (alu_op),
      .alu_start    (alu_start),
      .result       (result),
      .result_valid (result_valid),
      .error        (error),
      .busy         (busy),
      .state        (state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [9:0] d, input logic [2:0] op);
      load    = 1'b1;
      data_in = d;
      opcode  = op;
      tick();
      load    = 1'b0;
   endtask

   task automatic pulse_done(input logic [15:0] res, input logic err);
      alu_done   = 1'b1;
      alu_err    = err;
      alu_result = res;
      tick();
      alu_done   = 1'b0;
      alu_err    = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   initial begin
      int n;
      rst_n      = 1'b0;
      data_in    = '0;
      load       = 1'b0;
      opcode     = '0;
      clear      = 1'b0;
      alu_done   = 1'b0;
      alu_err    = 1'b0;
      alu_result = '0;
      #12;
      check("rst_state", state, 0);
      check("rst_outs", {op_a, op_b}, 0);
      check("rst_result", result, 0);
      check("rst_flags", {alu_op, alu_start, result_valid, error, busy}, 0);
      rst_n = 1'b1;
      tick();

      // Normal add
      do_load(10'b1101100110, ADD);
      check("add_state_b", state, 1);
      check("add_op_a", op_a, 16'h0366);
      do_load(10'b1111111111, ADD);
      check("add_state_exec", state, 2);
      check("add_start", alu_start, 1);
      check("add_busy", busy, 1);
      check("add_op_b", op_b, 16'h03FF);
      check("add_alu_op", alu_op, ADD);
      tick();
      check("add_start_one_cycle", alu_start, 0);
      check("add_state_wait", state, 3);
      tick();
      tick();
      pulse_done(16'h0765, 1'b0);
      check("add_state_show", state, 4);
      check("add_result", result, 16'h0765);
      check("add_valid", result_valid, 1);
      check("add_error", error, 0);
      check("add_busy_off", busy, 0);
      pulse_done(16'hDEAD, 1'b0);
      check("show_done_ignored", result, 16'h0765);

      // Chained entry from SHOW
      do_load(10'b1010101010, SUB);
      check("chain_state", state, 1);
      check("chain_valid", result_valid, 0);
      check("chain_op_a", op_a, 16'h02AA);
      check("chain_op_b_kept", op_b, 16'h03FF);
      do_clear();
      check("clear_wait_b", state, 0);
      check("clear_keeps_op_a", op_a, 16'h02AA);

      // Widening bounds, then ALU error
      do_load(10'b1000000000, SUB);
      check("wide_op_a", op_a, 16'h0200);
      do_load(10'b0111111111, SUB);
      check("wide_op_b", op_b, 16'h01FF);
      check("wide_alu_op", alu_op, SUB);
      tick();
      pulse_done(16'hBEEF, 1'b1);
      check("err_state", state, 5);
      check("err_error", error, 1);
      check("err_result_kept", result, 16'h0765);
      check("err_valid", result_valid, 0);
      do_load(10'h003, ADD);
      check("fault_load_ignored", {state, op_a}, {3'd5, 16'h0200});
      do_clear();
      check("fault_clear", {state, error}, {3'd0, 1'b0});

      // Timeout: ALU_DONE never arrives
      do_load(10'h005, MUL);
      do_load(10'h007, MUL);
      check("to_start", alu_start, 1);
      n = 0;
      while (error !== 1'b1 && n <= 400) begin
         tick();
         n++;
      end
      // First edge ends the start cycle; FAULT follows TIMEOUT+1 edges later.
      check("to_cycles", n, TIMEOUT + 2);
      check("to_state", state, 5);
      do_load(10'h011, ADD);
      check("to_load_ignored", state, 5);
      do_clear();
      check("to_clear", {state, error}, {3'd0, 1'b0});

      // ALU_DONE in the timeout cycle wins
      do_load(10'h005, DIV);
      do_load(10'h002, DIV);
      tick();
      repeat (TIMEOUT) tick();
      check("tie_still_wait", state, 3);
      pulse_done(16'h1234, 1'b0);
      check("tie_state", state, 4);
      check("tie_error", error, 0);
      check("tie_result", {result_valid, result}, {1'b1, 16'h1234});

      // CLEAR abandons WAIT_ALU; a late ALU_DONE is ignored
      do_load(10'h001, ADD);
      do_load(10'h002, ADD);
      tick();
      do_clear();
      check("abort_state", state, 0);
      check("abort_valid", result_valid, 0);
      pulse_done(16'h5555, 1'b0);
      check("late_done_state", state, 0);
      check("late_done_result", result, 16'h1234);

      // Asynchronous reset mid-WAIT_ALU, off the clock edge
      do_load(10'h0F0, MUL);
      do_load(10'h00F, MUL);
      tick();
      check("pre_rst_state", state, 3);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_ops", {op_a, op_b}, 0);
      check("async_rst_result", result, 0);
      check("async_rst_flags", {state, alu_op, alu_start, result_valid, error, busy}, 0);
      #3;
      rst_n = 1'b1;
      tick();

      // CLEAR with simultaneous LOAD in IDLE
      do_load(10'h155, ADD);
      do_clear();
      clear   = 1'b1;
      load    = 1'b1;
      data_in = 10'h0AA;
      tick();
      clear   = 1'b0;
      load    = 1'b0;
      check("clear_load_state", state, 0);
      check("clear_load_op_a", op_a, 16'h0155);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
